// File: rtl/accel_defs.sv
// rtl/accel_defs.sv - shared widths and round-sequencer state encoding
package accel_defs;

  localparam int DSP_RESULT_W = 48;
  localparam int OUT_W        = 18;
  localparam int FILTER_LEN_W = 13;
  localparam int NUM_ROUNDS_W = 16;
  localparam int SHIFT_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_EMIT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/dsp_result_narrow.sv
// rtl/dsp_result_narrow.sv - arithmetic right shift of a DSP result with signed saturation
module dsp_result_narrow #(
  parameter int OUT_W = accel_defs::OUT_W
) (
  input  logic signed [accel_defs::DSP_RESULT_W-1:0] din,
  input  logic        [accel_defs::SHIFT_W-1:0]      shift,
  output logic        [OUT_W-1:0]                    dout,
  output logic                                       sat
);

  localparam int DW = accel_defs::DSP_RESULT_W;

  logic signed [DW-1:0] s;
  logic                 fits;

  // s fits in OUT_W signed bits when everything above the output sign bit is sign extension
  always_comb begin
    s    = din >>> shift;
    fits = (s[DW-1:OUT_W-1] == '0) || (s[DW-1:OUT_W-1] == '1);
    sat  = !fits;
    if (fits)
      dout = s[OUT_W-1:0];
    else if (s[DW-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/dsp_round_sequencer.sv
// rtl/dsp_round_sequencer.sv - steps the DSP controller through N MAC rounds and emits narrowed results
module dsp_round_sequencer
  import accel_defs::*;
#(
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int OUT_W      = accel_defs::OUT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [FILTER_LEN_W-1:0]        cfg_filter_len,
  input  logic [NUM_ROUNDS_W-1:0]        cfg_num_rounds,
  input  logic [SHIFT_W-1:0]             cfg_shift,
  output logic                           round_rst,
  output logic [FILTER_LEN_W-1:0]        filter_length,
  input  logic signed [DSP_RESULT_W-1:0] dsp_result,
  input  logic                           dsp_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic [NUM_ROUNDS_W-1:0]        out_index,
  output logic                           busy,
  output logic                           done,
  output logic                           sat_flag,
  output logic                           timeout_err
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e              state, state_nxt;
  logic [CLR_W-1:0]        clr_cnt;
  logic [WD_W-1:0]         wd_cnt;
  logic                    run_armed;
  logic [NUM_ROUNDS_W-1:0] num_rounds_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic [NUM_ROUNDS_W-1:0] round_idx;
  logic [OUT_W-1:0]        narrow_data;
  logic                    narrow_sat;
  logic                    accept_start, got_result, wd_fire, last_round, handshake;

  dsp_result_narrow #(.OUT_W(OUT_W)) u_narrow (
    .din   (dsp_result),
    .shift (shift_q),
    .dout  (narrow_data),
    .sat   (narrow_sat)
  );

  // run_armed masks a result_ready left over from before the controller was cleared
  assign accept_start = (state == ST_IDLE) && start;
  assign got_result   = (state == ST_RUN) && run_armed && dsp_ready;
  assign wd_fire      = (TIMEOUT != 0) && (state == ST_RUN) && !got_result
                        && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign last_round   = (round_idx == num_rounds_q - 16'd1);
  assign handshake    = (state == ST_EMIT) && out_ready;
  assign out_index    = round_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    round_rst = (state != ST_RUN);
    out_valid = (state == ST_EMIT);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (start) state_nxt = (cfg_num_rounds == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR: if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = ST_RUN;
      ST_RUN:   if (got_result || wd_fire) state_nxt = ST_EMIT;
      ST_EMIT:  if (out_ready) state_nxt = last_round ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt       <= '0;
      wd_cnt        <= '0;
      run_armed     <= 1'b0;
      num_rounds_q  <= '0;
      shift_q       <= '0;
      round_idx     <= '0;
      filter_length <= '0;
      out_data      <= '0;
      sat_flag      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      clr_cnt   <= (state == ST_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      wd_cnt    <= (state == ST_RUN) ? wd_cnt + WD_W'(1) : '0;
      run_armed <= (state == ST_RUN);
      if (accept_start) begin
        filter_length <= cfg_filter_len;
        num_rounds_q  <= cfg_num_rounds;
        shift_q       <= cfg_shift;
        round_idx     <= '0;
        sat_flag      <= 1'b0;
        timeout_err   <= 1'b0;
      end
      if (got_result) begin
        out_data <= narrow_data;
        sat_flag <= sat_flag | narrow_sat;
      end else if (wd_fire) begin
        out_data    <= '0;
        timeout_err <= 1'b1;
      end
      if (handshake && !last_round)
        round_idx <= round_idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_dsp_round_sequencer.sv
// tb/tb_dsp_round_sequencer.sv - directed self-checking bench for dsp_round_sequencer
module tb_dsp_round_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [12:0]        cfg_filter_len;
  logic [15:0]        cfg_num_rounds;
  logic [5:0]         cfg_shift;
  logic               round_rst;
  logic [12:0]        filter_length;
  logic signed [47:0] dsp_result;
  logic               dsp_ready;
  logic               out_valid;
  logic               out_ready;
  logic [17:0]        out_data;
  logic [15:0]        out_index;
  logic               busy;
  logic               done;
  logic               sat_flag;
  logic               timeout_err;

  int total = 0;
  int bad   = 0;

  dsp_round_sequencer #(.CLR_CYCLES(2), .TIMEOUT(16), .OUT_W(18)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_filter_len(cfg_filter_len),
    .cfg_num_rounds(cfg_num_rounds), .cfg_shift(cfg_shift), .round_rst(round_rst),
    .filter_length(filter_length), .dsp_result(dsp_result), .dsp_ready(dsp_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .sat_flag(sat_flag),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [12:0] len, input logic [15:0] rounds, input logic [5:0] sh);
    cfg_filter_len = len;
    cfg_num_rounds = rounds;
    cfg_shift      = sh;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  // called on the first CLEAR cycle; CLEAR must last exactly two cycles
  task automatic wait_run(input string tag);
    int n = 0;
    while (round_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_clear_len"}, 48'(n), 48'd2);
  endtask

  task automatic do_round(input string tag, input logic signed [47:0] res,
                          input logic [17:0] exp_data, input logic [15:0] exp_idx, input int hold);
    wait_run(tag);
    dsp_result = res;
    dsp_ready  = 1'b1;
    tick();
    chk({tag, "_stale_guard"}, 48'(out_valid), 48'd0);
    tick();
    dsp_ready = 1'b0;
    chk({tag, "_valid"}, 48'(out_valid), 48'd1);
    chk({tag, "_data"}, 48'(out_data), 48'(exp_data));
    chk({tag, "_index"}, 48'(out_index), 48'(exp_idx));
    chk({tag, "_rst_emit"}, 48'(round_rst), 48'd1);
    for (int i = 0; i < hold; i++) begin
      dsp_result = 48'h0000_000A_BCDE;
      tick();
      chk({tag, "_hold_valid"}, 48'(out_valid), 48'd1);
      chk({tag, "_hold_data"}, 48'(out_data), 48'(exp_data));
      chk({tag, "_hold_index"}, 48'(out_index), 48'(exp_idx));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_filter_len = '0; cfg_num_rounds = '0; cfg_shift = '0;
    dsp_result = '0; dsp_ready = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_round_rst", 48'(round_rst), 48'd1);
    chk("rst_out_valid", 48'(out_valid), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_sat", 48'(sat_flag), 48'd0);
    chk("rst_timeout", 48'(timeout_err), 48'd0);
    chk("rst_out_data", 48'(out_data), 48'd0);
    chk("rst_out_index", 48'(out_index), 48'd0);
    chk("rst_filter_len", 48'(filter_length), 48'd0);
    rst = 1'b0;
    tick();

    // single round, cfg changed mid-job must not leak into filter_length
    pulse_start(13'd4, 16'd1, 6'd0);
    chk("r1_busy", 48'(busy), 48'd1);
    chk("r1_filter_len", 48'(filter_length), 48'd4);
    cfg_filter_len = 13'd99;
    start = 1'b1;
    do_round("r1", 48'sd100, 18'd100, 16'd0, 0);
    start = 1'b0;
    chk("r1_done", 48'(done), 48'd1);
    chk("r1_done_busy", 48'(busy), 48'd1);
    chk("r1_filter_len_held", 48'(filter_length), 48'd4);
    tick();
    chk("r1_done_pulse", 48'(done), 48'd0);
    chk("r1_idle_busy", 48'(busy), 48'd0);
    chk("r1_sat", 48'(sat_flag), 48'd0);

    // three rounds with backpressure
    pulse_start(13'd8, 16'd3, 6'd0);
    do_round("m0", 48'sd5, 18'h00005, 16'd0, 5);
    chk("m0_no_done", 48'(done), 48'd0);
    do_round("m1", -48'sd7, 18'h3FFF9, 16'd1, 5);
    chk("m1_no_done", 48'(done), 48'd0);
    do_round("m2", 48'sd1000, 18'h003E8, 16'd2, 5);
    chk("m2_done", 48'(done), 48'd1);
    tick();
    chk("m2_done_once", 48'(done), 48'd0);
    chk("m2_sat", 48'(sat_flag), 48'd0);

    // shift and saturation
    pulse_start(13'd2, 16'd3, 6'd4);
    do_round("s0", 48'sh1_0000_0000, 18'h1FFFF, 16'd0, 0);
    chk("s0_sat", 48'(sat_flag), 48'd1);
    do_round("s1", -48'sd1600, 18'h3FF9C, 16'd1, 0);
    do_round("s2", -(48'sd1 <<< 40), 18'h20000, 16'd2, 0);
    chk("s2_done", 48'(done), 48'd1);
    chk("s2_sat_sticky", 48'(sat_flag), 48'd1);
    tick();

    // zero-round job
    pulse_start(13'd3, 16'd0, 6'd0);
    chk("z_done", 48'(done), 48'd1);
    chk("z_valid", 48'(out_valid), 48'd0);
    chk("z_round_rst", 48'(round_rst), 48'd1);
    chk("z_sat_cleared", 48'(sat_flag), 48'd0);
    tick();
    chk("z_done_pulse", 48'(done), 48'd0);
    chk("z_busy", 48'(busy), 48'd0);
    chk("z_round_rst2", 48'(round_rst), 48'd1);

    // watchdog
    pulse_start(13'd5, 16'd1, 6'd0);
    wait_run("t");
    for (int i = 0; i < 15; i++) tick();
    chk("t_pre_valid", 48'(out_valid), 48'd0);
    chk("t_pre_err", 48'(timeout_err), 48'd0);
    tick();
    chk("t_err", 48'(timeout_err), 48'd1);
    chk("t_valid", 48'(out_valid), 48'd1);
    chk("t_data", 48'(out_data), 48'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t_done", 48'(done), 48'd1);
    tick();

    // reset mid-job, then a clean restart
    pulse_start(13'd6, 16'd3, 6'd0);
    do_round("a0", 48'sd11, 18'd11, 16'd0, 0);
    wait_run("a1");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("a_round_rst", 48'(round_rst), 48'd1);
    chk("a_busy", 48'(busy), 48'd0);
    chk("a_valid", 48'(out_valid), 48'd0);
    chk("a_timeout_cleared", 48'(timeout_err), 48'd0);
    tick();
    pulse_start(13'd7, 16'd1, 6'd0);
    chk("b_filter_len", 48'(filter_length), 48'd7);
    do_round("b0", 48'sd42, 18'd42, 16'd0, 1);
    chk("b_done", 48'(done), 48'd1);
    tick();
    chk("b_idle", 48'(busy), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
